// File: rtl/mem_c_reader.sv
// Streams the 64x64 result matrix out of MEM_C in index order, tagged with row/column, with an exact checksum.
// Latency: start sampled at edge T0, first SRAM read issued in the next cycle, out_valid from edge T0+2.
// Backpressure: 2-entry buffer; reads stop once buffered + in-flight words would exceed 2, out_* held while stalled.
module mem_c_reader #(
   parameter int DATA_W = 22,
   parameter int IDX_W  = 12,
   parameter int MUX_W  = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic                      busy,
   output logic                      done,
   output logic [IDX_W-MUX_W-1:0]    mem_a,
   output logic [MUX_W-1:0]          mem_mux,
   output logic                      mem_nce,
   output logic                      mem_nwrt,
   input  logic [DATA_W-1:0]         mem_q,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATA_W-1:0]         out_data,
   output logic [5:0]                out_row,
   output logic [5:0]                out_col,
   output logic [DATA_W+IDX_W-1:0]   checksum
);

   typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] dat;
   } entry_t;

   localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

   state_t           state_q, state_d;
   logic [IDX_W-1:0] rd_idx;
   logic [1:0]       occ;        // words held in the buffer
   entry_t           slot0;      // buffer head
   entry_t           slot1;
   logic             fly;        // a read was issued on the previous edge
   logic [IDX_W-1:0] fly_idx;    // index tag travelling with that read
   logic [2:0]       level;      // buffered + in-flight words after this edge, before any new issue
   logic             pop;
   logic             issue;
   entry_t           new_entry;

   assign out_valid = (occ != 2'd0);
   assign pop       = out_valid && out_ready;
   assign new_entry = '{idx: fly_idx, dat: mem_q};

   // Issue gate and next-state logic; a slot freed by this cycle's transfer is reusable immediately.
   always_comb begin
      state_d = state_q;
      level   = 3'(occ) + 3'(fly) - 3'(pop);
      issue   = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) state_d = READ;
         end
         READ: begin
            issue = (level < 3'd2);
            if (issue && rd_idx == LAST_IDX) state_d = DRAIN;
         end
         DRAIN: begin
            if (level == 3'd0) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy     = (state_q == READ) || (state_q == DRAIN);
   assign done     = (state_q == DONE);
   assign mem_nce  = ~issue;
   assign mem_nwrt = 1'b1;
   assign mem_a    = rd_idx[IDX_W-1:MUX_W];
   assign mem_mux  = rd_idx[MUX_W-1:0];
   assign out_data = out_valid ? slot0.dat : '0;
   assign out_row  = out_valid ? slot0.idx[IDX_W-1 -: 6] : 6'd0;
   assign out_col  = out_valid ? slot0.idx[5:0] : 6'd0;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Read index, tag pipe, 2-entry buffer and checksum.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_idx   <= '0;
         occ      <= 2'd0;
         slot0    <= '0;
         slot1    <= '0;
         fly      <= 1'b0;
         fly_idx  <= '0;
         checksum <= '0;
      end else if (state_q == IDLE && start) begin
         rd_idx   <= '0;
         occ      <= 2'd0;
         fly      <= 1'b0;
         checksum <= '0;
      end else begin
         if (issue) rd_idx <= rd_idx + IDX_W'(1);
         fly     <= issue;
         fly_idx <= rd_idx;
         if (pop) checksum <= checksum + {{IDX_W{1'b0}}, out_data};
         case ({fly, pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= new_entry;
               else             slot1 <= new_entry;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  slot0 <= new_entry;
               end else begin
                  slot0 <= slot1;
                  slot1 <= new_entry;
               end
            end
            default: ;
         endcase
      end
   end

   // The buffer must never receive a word while full and not draining.
   assert property (@(posedge clk) disable iff (rst) !(fly && !pop && occ == 2'd2));

endmodule
